// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mips_ctrl_pkg : states, opcode/func codes and mux encodings for the      |
// | multicycle MIPS controller.                            Rev 1.0           |
// +---------------------------------------------------------------------------+
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ACLS_ADD  = 2'd0,
        ACLS_SUB  = 2'd1,
        ACLS_FUNC = 2'd2,
        ACLS_SLT  = 2'd3
    } alu_class_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_JR  = 6'b001000;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_REG    = 2'b11;

    function automatic logic is_rtype_alu(input logic [5:0] fn);
        return (fn == c_FN_ADD) || (fn == c_FN_SUB) || (fn == c_FN_AND) ||
               (fn == c_FN_OR)  || (fn == c_FN_SLT);
    endfunction

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            c_OP_RTYPE: return is_rtype_alu(fn) || (fn == c_FN_JR);
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI,
            c_OP_SLTI, c_OP_J, c_OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mips_alu_decoder : maps the state's ALU class plus func to AluOperation. |
// | Rev 1.0                                                                  |
// +---------------------------------------------------------------------------+
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_class,
    input  logic [5:0] i_func,
    output logic [2:0] o_alu_op
);

    always_comb begin
        o_alu_op = c_ALU_ADD;
        case (i_alu_class)
            ACLS_ADD: o_alu_op = c_ALU_ADD;
            ACLS_SUB: o_alu_op = c_ALU_SUB;
            ACLS_SLT: o_alu_op = c_ALU_SLT;
            ACLS_FUNC: begin
                case (i_func)
                    c_FN_ADD: o_alu_op = c_ALU_ADD;
                    c_FN_SUB: o_alu_op = c_ALU_SUB;
                    c_FN_AND: o_alu_op = c_ALU_AND;
                    c_FN_OR:  o_alu_op = c_ALU_OR;
                    c_FN_SLT: o_alu_op = c_ALU_SLT;
                    default:  o_alu_op = c_ALU_ADD;
                endcase
            end
            default: o_alu_op = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mips_multicycle_controller : Moore FSM sequencing the multicycle MIPS    |
// | datapath. Optional memory stall handshake: MIPS_MC_MEM_STALL_EN. Rev 1.0 |
// +---------------------------------------------------------------------------+
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_ld,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             R31,
    output logic             WriteLink,
    output logic             MemToReg,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       PcSrc,
    output logic [2:0]       AluOperation,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    alu_class_t       w_alu_cls;
    logic [CNT_W-1:0] r_count;
    logic             w_mem_ok;
    logic             w_pc_ld, w_irw, w_mrd, w_mwr, w_rw, w_done, w_ill;

`ifdef MIPS_MC_MEM_STALL_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Memory states hold in place until the access completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_mem_ok) w_next = S_DECODE;
            S_DECODE: begin
                if (!is_supported(opcode, func)) begin
                    w_next = S_FETCH;
                end else begin
                    case (opcode)
                        c_OP_LW, c_OP_SW:     w_next = S_MEM_ADDR;
                        c_OP_RTYPE:           w_next = (func == c_FN_JR) ? S_JR : S_R_EXEC;
                        c_OP_ADDI, c_OP_SLTI: w_next = S_I_EXEC;
                        c_OP_BEQ:             w_next = S_BRANCH;
                        c_OP_J:               w_next = S_JUMP;
                        c_OP_JAL:             w_next = S_JAL;
                        default:              w_next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: w_next = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (w_mem_ok) w_next = S_MEM_WB;
            S_MEM_WR:   if (w_mem_ok) w_next = S_FETCH;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_ld   = 1'b0;
        w_irw     = 1'b0;
        w_mrd     = 1'b0;
        w_mwr     = 1'b0;
        w_rw      = 1'b0;
        w_done    = 1'b0;
        w_ill     = 1'b0;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        R31       = 1'b0;
        WriteLink = 1'b0;
        MemToReg  = 1'b0;
        AluSrcA   = 1'b0;
        AluSrcB   = c_SRCB_B;
        PcSrc     = c_PCSRC_ALU;
        w_alu_cls = ACLS_ADD;
        case (r_state)
            S_FETCH: begin
                w_mrd   = 1'b1;
                w_irw   = w_mem_ok;
                w_pc_ld = w_mem_ok;
                AluSrcB = c_SRCB_FOUR;
            end
            S_DECODE: begin
                AluSrcB = c_SRCB_IMM_SH;
                w_ill   = !is_supported(opcode, func);
            end
            S_MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = c_SRCB_IMM;
            end
            S_MEM_RD: begin
                IorD  = 1'b1;
                w_mrd = 1'b1;
            end
            S_MEM_WB: begin
                MemToReg = 1'b1;
                w_rw     = 1'b1;
                w_done   = 1'b1;
            end
            S_MEM_WR: begin
                IorD   = 1'b1;
                w_mwr  = 1'b1;
                w_done = w_mem_ok;
            end
            S_R_EXEC: begin
                AluSrcA   = 1'b1;
                w_alu_cls = ACLS_FUNC;
            end
            S_R_WB: begin
                RegDst = 1'b1;
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            S_I_EXEC: begin
                AluSrcA   = 1'b1;
                AluSrcB   = c_SRCB_IMM;
                w_alu_cls = (opcode == c_OP_SLTI) ? ACLS_SLT : ACLS_ADD;
            end
            S_I_WB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA   = 1'b1;
                w_alu_cls = ACLS_SUB;
                PcSrc     = c_PCSRC_ALUOUT;
                w_pc_ld   = zero;
                w_done    = 1'b1;
            end
            S_JUMP: begin
                PcSrc   = c_PCSRC_JUMP;
                w_pc_ld = 1'b1;
                w_done  = 1'b1;
            end
            S_JAL: begin
                PcSrc     = c_PCSRC_JUMP;
                w_pc_ld   = 1'b1;
                R31       = 1'b1;
                WriteLink = 1'b1;
                w_rw      = 1'b1;
                w_done    = 1'b1;
            end
            S_JR: begin
                PcSrc   = c_PCSRC_REG;
                w_pc_ld = 1'b1;
                w_done  = 1'b1;
            end
            default: ;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .i_alu_class (w_alu_cls),
        .i_func      (func),
        .o_alu_op    (AluOperation)
    );

    // Reset suppresses every side effect so an abandoned instruction writes nothing.
    assign pc_ld       = w_pc_ld & ~rst;
    assign IRWrite     = w_irw   & ~rst;
    assign MemRead     = w_mrd   & ~rst;
    assign MemWrite    = w_mwr   & ~rst;
    assign RegWrite    = w_rw    & ~rst;
    assign instr_done  = w_done  & ~rst;
    assign illegal     = w_ill   & ~rst;
    assign instr_count = r_count;

endmodule
`default_nettype wire
